// File: rtl/qspi_rx_fifo.sv
// qspi_rx_fifo: groups nibble strobes from qspi_rx_shift into 32-bit words.
// Each completed word is pushed into a DEPTH-entry first-word-fall-through FIFO.
// The FIFO is read through a valid/ready port.
// Optional feature macro: QSPI_RX_FIFO_THRESH_EN enables the fill-threshold flag thresh_o.
// Without that macro, thresh_o is tied low.

module qspi_rx_fifo #(
    parameter int DEPTH   = 8,
    parameter int NIBBLES = 8,
    parameter int THRESH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       shift_valid_i,
    input  logic [31:0]                rx_word_i,
    input  logic                       clr_i,
    input  logic                       rd_ready_i,
    output logic                       rd_valid_o,
    output logic [31:0]                rd_data_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       overflow_o,
    output logic                       thresh_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [2:0]    NIB_LAST  = 3'(NIBBLES - 1);
    localparam logic [PW-1:0] DEPTH_LVL = PW'(DEPTH);

    logic [2:0]    nib_cnt;
    logic          cap_pend;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          overflow_q;
    logic [31:0]   mem [DEPTH];

    logic [PW-1:0] level;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          wr_en;
    logic          drop;

    // The extra pointer MSB lets the difference span 0..DEPTH.
    assign level = wr_ptr - rd_ptr;
    assign empty = (level == '0);
    assign full  = (level == DEPTH_LVL);

    // A capture is pending for exactly the one cycle after the last nibble.
    // At that point the shifter's word is stable.
    // When the FIFO is full, a push still lands if a pop frees a slot in the same cycle.
    assign push  = cap_pend;
    assign pop   = !empty && rd_ready_i;
    assign wr_en = push && (!full || pop) && !clr_i;
    assign drop  = push && full && !pop;

    // Count nibble strobes and flag the cycle in which the assembled word is taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            nib_cnt  <= '0;
            cap_pend <= 1'b0;
        end else if (clr_i) begin
            nib_cnt  <= '0;
            cap_pend <= 1'b0;
        end else begin
            cap_pend <= shift_valid_i && (nib_cnt == NIB_LAST);
            if (shift_valid_i) begin
                nib_cnt <= (nib_cnt == NIB_LAST) ? 3'd0 : nib_cnt + 3'd1;
            end
        end
    end

    // Advance the write pointer on accepted pushes and the read pointer on pops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Sticky flag set when a completed word finds no room.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else if (clr_i) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    // Word storage is not reset; the pointers alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= rx_word_i;
        end
    end

    assign rd_valid_o = !empty;
    assign rd_data_o  = empty ? 32'd0 : mem[rd_ptr[AW-1:0]];
    assign level_o    = level;
    assign full_o     = full;
    assign empty_o    = empty;
    assign overflow_o = overflow_q;

`ifdef QSPI_RX_FIFO_THRESH_EN
    localparam logic [PW-1:0] THRESH_LVL = PW'(THRESH);
    assign thresh_o = (level >= THRESH_LVL);
`else
    assign thresh_o = 1'b0;
`endif

endmodule

// File: tb/tb_qspi_rx_fifo.sv
// Testbench for qspi_rx_fifo (default parameters DEPTH=8, NIBBLES=8, THRESH=4).
// Honours QSPI_RX_FIFO_THRESH_EN when it is defined for the build.

module tb_qspi_rx_fifo;

    localparam int DEPTH   = 8;
    localparam int NIBBLES = 8;
    localparam int THRESH  = 4;
`ifdef QSPI_RX_FIFO_THRESH_EN
    localparam bit THRESH_EN = 1'b1;
`else
    localparam bit THRESH_EN = 1'b0;
`endif

    logic        clk_i;
    logic        rst_ni;
    logic        shift_valid_i;
    logic [31:0] rx_word_i;
    logic        clr_i;
    logic        rd_ready_i;
    logic        rd_valid_o;
    logic [31:0] rd_data_o;
    logic [3:0]  level_o;
    logic        full_o;
    logic        empty_o;
    logic        overflow_o;
    logic        thresh_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a word queue plus a nibble counter.
    logic [31:0] m_q[$];
    int          m_cnt;
    bit          m_pend;
    bit          m_ovf;

    typedef struct {
        bit          sv;
        logic [31:0] w;
        bit          clr;
        bit          rdy;
        int          lvl;
        bit          val;
        logic [31:0] data;
    } vec_t;
    vec_t vecs[$];

    qspi_rx_fifo #(.DEPTH(DEPTH), .NIBBLES(NIBBLES), .THRESH(THRESH)) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .shift_valid_i(shift_valid_i),
        .rx_word_i(rx_word_i),
        .clr_i(clr_i),
        .rd_ready_i(rd_ready_i),
        .rd_valid_o(rd_valid_o),
        .rd_data_o(rd_data_o),
        .level_o(level_o),
        .full_o(full_o),
        .empty_o(empty_o),
        .overflow_o(overflow_o),
        .thresh_o(thresh_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void modelReset();
        m_q.delete();
        m_cnt  = 0;
        m_pend = 1'b0;
        m_ovf  = 1'b0;
    endfunction

    function automatic void modelEdge(bit sv, logic [31:0] w, bit clr, bit rdy);
        int  sz;
        bit  pop;
        if (clr) begin
            modelReset();
            return;
        end
        sz  = m_q.size();
        pop = (sz > 0) && rdy;
        if (pop) void'(m_q.pop_front());
        if (m_pend) begin
            if (sz == DEPTH && !pop) m_ovf = 1'b1;
            else m_q.push_back(w);
        end
        m_pend = sv && (m_cnt == NIBBLES - 1);
        if (sv) m_cnt = (m_cnt + 1) % NIBBLES;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        int sz;
        sz = m_q.size();
        cmp({tag, ".valid"}, 32'(rd_valid_o), 32'(sz != 0));
        cmp({tag, ".data"},  rd_data_o, (sz != 0) ? m_q[0] : 32'd0);
        cmp({tag, ".level"}, 32'(level_o), 32'(sz));
        cmp({tag, ".full"},  32'(full_o), 32'(sz == DEPTH));
        cmp({tag, ".empty"}, 32'(empty_o), 32'(sz == 0));
        cmp({tag, ".ovf"},   32'(overflow_o), 32'(m_ovf));
        cmp({tag, ".thresh"}, 32'(thresh_o), 32'(THRESH_EN && sz >= THRESH));
    endtask

    task automatic applyStimulus(input bit sv, input logic [31:0] w, input bit clr, input bit rdy);
        shift_valid_i = sv;
        rx_word_i     = w;
        clr_i         = clr;
        rd_ready_i    = rdy;
        @(posedge clk_i);
        if (rst_ni) modelEdge(sv, w, clr, rdy);
        #1;
    endtask

    task automatic pushWord(input logic [31:0] w, input bit rdy_last, input string tag);
        for (int i = 0; i < NIBBLES; i++) begin
            applyStimulus(1'b1, w, 1'b0, 1'b0);
            checkOutput(tag);
        end
        applyStimulus(1'b0, w, 1'b0, rdy_last);
        checkOutput(tag);
    endtask

    function automatic void addVec(bit sv, logic [31:0] w, bit clr, bit rdy,
                                   int lvl, bit val, logic [31:0] data);
        vec_t v;
        v.sv = sv; v.w = w; v.clr = clr; v.rdy = rdy;
        v.lvl = lvl; v.val = val; v.data = data;
        vecs.push_back(v);
    endfunction

    initial begin
        shift_valid_i = 1'b0;
        rx_word_i     = '0;
        clr_i         = 1'b0;
        rd_ready_i    = 1'b0;
        rst_ni        = 1'b0;
        modelReset();

        // Single word latency, pop, ready-while-empty.
        for (int i = 0; i < 7; i++) addVec(1, 32'h12345678, 0, 0, 0, 0, 32'h0);
        addVec(1, 32'h12345678, 0, 0, 0, 0, 32'h0);
        addVec(0, 32'h12345678, 0, 0, 1, 1, 32'h12345678);
        addVec(0, 32'h0, 0, 1, 0, 0, 32'h0);
        addVec(0, 32'h0, 0, 1, 0, 0, 32'h0);
        // Partial word discarded by clear (which also beats a strobe).
        for (int i = 0; i < 5; i++) addVec(1, 32'h55555555, 0, 0, 0, 0, 32'h0);
        addVec(1, 32'h55555555, 1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 8; i++) addVec(1, 32'hCAFEF00D, 0, 0, 0, 0, 32'h0);
        addVec(0, 32'hCAFEF00D, 0, 0, 1, 1, 32'hCAFEF00D);
        addVec(0, 32'h0, 0, 0, 1, 1, 32'hCAFEF00D);
        addVec(0, 32'h0, 0, 1, 0, 0, 32'h0);

        // Reset values.
        repeat (2) @(posedge clk_i);
        #1;
        cmp("rst.valid", 32'(rd_valid_o), 32'd0);
        cmp("rst.data", rd_data_o, 32'd0);
        cmp("rst.level", 32'(level_o), 32'd0);
        cmp("rst.full", 32'(full_o), 32'd0);
        cmp("rst.empty", 32'(empty_o), 32'd1);
        cmp("rst.ovf", 32'(overflow_o), 32'd0);
        cmp("rst.thresh", 32'(thresh_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].sv, vecs[i].w, vecs[i].clr, vecs[i].rdy);
            cmp($sformatf("vec%0d.level", i), 32'(level_o), 32'(vecs[i].lvl));
            cmp($sformatf("vec%0d.valid", i), 32'(rd_valid_o), 32'(vecs[i].val));
            cmp($sformatf("vec%0d.data", i), rd_data_o, vecs[i].data);
        end

        // Fill to full, overflow drop, ordered drain.
        applyStimulus(0, 0, 1, 0);
        for (int i = 0; i < 8; i++) pushWord(32'(i), 1'b0, "t2.fill");
        cmp("t2.full", 32'(full_o), 32'd1);
        cmp("t2.level8", 32'(level_o), 32'd8);
        pushWord(32'hDEAD, 1'b0, "t2.ovf");
        cmp("t2.overflow", 32'(overflow_o), 32'd1);
        cmp("t2.level_ovf", 32'(level_o), 32'd8);
        for (int i = 0; i < 8; i++) begin
            cmp($sformatf("t2.drain%0d", i), rd_data_o, 32'(i));
            applyStimulus(0, 0, 0, 1);
            checkOutput("t2.drain");
        end
        cmp("t2.empty", 32'(empty_o), 32'd1);
        cmp("t2.ovf_sticky", 32'(overflow_o), 32'd1);

        // Full FIFO with capture and pop on the same edge.
        applyStimulus(0, 0, 1, 0);
        checkOutput("t3.clr");
        for (int i = 0; i < 8; i++) pushWord(32'h100 + 32'(i), 1'b0, "t3.fill");
        pushWord(32'hBEEF, 1'b1, "t3.both");
        cmp("t3.level", 32'(level_o), 32'd8);
        cmp("t3.noovf", 32'(overflow_o), 32'd0);
        for (int i = 1; i < 8; i++) begin
            cmp($sformatf("t3.drain%0d", i), rd_data_o, 32'h100 + 32'(i));
            applyStimulus(0, 0, 0, 1);
        end
        cmp("t3.last", rd_data_o, 32'hBEEF);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t3.end");

        // Asynchronous reset between edges with words held.
        for (int i = 0; i < 3; i++) pushWord(32'hA0 + 32'(i), 1'b0, "t5.fill");
        cmp("t5.level3", 32'(level_o), 32'd3);
        #2;
        rst_ni = 1'b0;
        #1;
        modelReset();
        cmp("t5.empty", 32'(empty_o), 32'd1);
        cmp("t5.valid", 32'(rd_valid_o), 32'd0);
        cmp("t5.data", rd_data_o, 32'd0);
        cmp("t5.level0", 32'(level_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        pushWord(32'h0BADF00D, 1'b0, "t5.after");
        cmp("t5.one", 32'(level_o), 32'd1);
        cmp("t5.word", rd_data_o, 32'h0BADF00D);

        // Threshold flag rise and fall.
        applyStimulus(0, 0, 1, 0);
        for (int k = 1; k <= 4; k++) begin
            pushWord(32'hC0 + 32'(k), 1'b0, "t6.fill");
            cmp($sformatf("t6.thresh_push%0d", k), 32'(thresh_o), 32'(THRESH_EN && k >= 4));
        end
        applyStimulus(0, 0, 0, 1);
        cmp("t6.thresh_pop", 32'(thresh_o), 32'd0);
        cmp("t6.level3", 32'(level_o), 32'd3);

        // Randomized traffic against the model.
        applyStimulus(0, 0, 1, 0);
        for (int c = 0; c < 4000; c++) begin
            applyStimulus($urandom_range(0, 9) < 8, $urandom, $urandom_range(0, 249) == 0,
                          $urandom_range(0, 9) < ((c / 500) % 2 ? 2 : 6));
            checkOutput("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
